// File: rtl/ins_inject_assembler_if.sv
// Bundle of the inject PIO inputs, instruction-memory write port and status word
// shared between the inject assembler (slave) and its environment (master).
interface ins_inject_assembler_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        inject_data;
    logic              inject_strobe;
    logic              inject_start;
    logic              imem_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic [31:0]       status;

    modport master (
        output inject_data, inject_strobe, inject_start, imem_ready,
        input  imem_wr_en, imem_addr, imem_wdata, cpu_hold, status
    );

    modport slave (
        input  inject_data, inject_strobe, inject_start, imem_ready,
        output imem_wr_en, imem_addr, imem_wdata, cpu_hold, status
    );
endinterface

// File: rtl/ins_inject_assembler.sv
// Packs PIO-injected bytes little-endian into 32-bit instructions and writes them to imem.
// Optional INJECT_CHECKSUM_EN adds an 8-bit running sum of accepted bytes to status[27:20].
module ins_inject_assembler #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input logic                   clk,
    input logic                   reset_n,
    ins_inject_assembler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FLUSH} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_strbQ;
    logic              r_startQ;
    logic [1:0]        r_byteIdx;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wordCnt;
    logic              r_ovf;
    logic              r_ovr;
    logic              r_part;
    logic              r_stopPend;
    logic              r_cpuHold;
    logic [7:0]        w_checksum;

    logic w_byteEv, w_startRise, w_startFall, w_full;
    logic w_begin, w_accept, w_dropFull, w_dropBusy, w_done, w_abandon;

    assign w_byteEv    = bus.inject_strobe ^ r_strbQ;
    assign w_startRise = bus.inject_start & ~r_startQ;
    assign w_startFall = ~bus.inject_start & r_startQ;
    assign w_full      = (r_wordCnt == 16'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // A falling start always wins over a coincident byte, in both COLLECT and WRITE.
    always_comb begin
        w_nextState = r_state;
        w_begin     = 1'b0;
        w_accept    = 1'b0;
        w_dropFull  = 1'b0;
        w_dropBusy  = 1'b0;
        w_done      = 1'b0;
        w_abandon   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startRise) begin
                    w_begin     = 1'b1;
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (w_startFall) begin
                    w_abandon   = (r_byteIdx != 2'd0);
                    w_nextState = FLUSH;
                end else if (w_byteEv) begin
                    if (w_full) begin
                        w_dropFull = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        if (r_byteIdx == 2'd3) w_nextState = WRITE;
                    end
                end
            end
            WRITE: begin
                w_dropBusy = w_byteEv & ~w_startFall;
                if (bus.imem_ready) begin
                    w_done      = 1'b1;
                    w_nextState = (r_stopPend || w_startFall) ? FLUSH : COLLECT;
                end
            end
            FLUSH:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_strbQ    <= 1'b0;
            r_startQ   <= 1'b0;
            r_byteIdx  <= 2'd0;
            r_word     <= 32'd0;
            r_addr     <= '0;
            r_wordCnt  <= 16'd0;
            r_ovf      <= 1'b0;
            r_ovr      <= 1'b0;
            r_part     <= 1'b0;
            r_stopPend <= 1'b0;
            r_cpuHold  <= 1'b0;
        end else begin
            r_strbQ  <= bus.inject_strobe;
            r_startQ <= bus.inject_start;
            if (w_begin) begin
                r_byteIdx  <= 2'd0;
                r_word     <= 32'd0;
                r_addr     <= ADDR_W'(BASE_ADDR);
                r_wordCnt  <= 16'd0;
                r_ovf      <= 1'b0;
                r_ovr      <= 1'b0;
                r_part     <= 1'b0;
                r_stopPend <= 1'b0;
                r_cpuHold  <= 1'b1;
            end
            if (w_accept) begin
                r_word[{r_byteIdx, 3'b000} +: 8] <= bus.inject_data;
                r_byteIdx                        <= r_byteIdx + 2'd1;
            end
            if (w_dropFull) r_ovf  <= 1'b1;
            if (w_dropBusy) r_ovr  <= 1'b1;
            if (w_abandon)  r_part <= 1'b1;
            if (r_state == WRITE && w_startFall) r_stopPend <= 1'b1;
            // Address wraps naturally at 2**ADDR_W; DEPTH is enforced through word count.
            if (w_done) begin
                r_wordCnt  <= r_wordCnt + 16'd1;
                r_addr     <= r_addr + 1'b1;
                r_byteIdx  <= 2'd0;
                r_stopPend <= 1'b0;
            end
            if (r_state == FLUSH) r_cpuHold <= 1'b0;
        end
    end

`ifdef INJECT_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_checksum <= 8'd0;
        else if (w_begin)  r_checksum <= 8'd0;
        else if (w_accept) r_checksum <= r_checksum + bus.inject_data;
    end

    assign w_checksum = r_checksum;
`else
    assign w_checksum = 8'd0;
`endif

    assign bus.imem_wr_en = (r_state == WRITE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_word;
    assign bus.cpu_hold   = r_cpuHold;
    assign bus.status     = {r_ovf, r_ovr, r_part, (r_state != IDLE), w_checksum, 4'b0000, r_wordCnt};
endmodule

// File: tb/tb_ins_inject_assembler.sv
// Randomized self-checking bench: a queue-based session model predicts written words,
// addresses and the final status word of every load session.
module tb_ins_inject_assembler;
    localparam int ADDR_W    = 2;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 2;
    localparam int ASPACE    = 1 << ADDR_W;
`ifdef INJECT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ins_inject_assembler_if #(.ADDR_W(ADDR_W)) bus ();

    ins_inject_assembler #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  txBytes[$];
    logic [31:0] expData[$];
    int          expAddr[$];
    logic [31:0] obsData[$];
    int          obsWrites  = 0;
    bit          expWr      = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Inputs are already set for the coming edge; memory handshakes are logged before it.
    task automatic tick();
        checkOutput("wr_en", 32'(bus.imem_wr_en), 32'(expWr));
        if (bus.imem_wr_en) begin
            if (expData.size() == 0) begin
                checkOutput("spurious_write", 32'(bus.imem_wr_en), 32'd0);
            end else begin
                checkOutput("wr_addr", 32'(bus.imem_addr), 32'(expAddr[0]));
                checkOutput("wr_data", bus.imem_wdata, expData[0]);
                if (bus.imem_ready) begin
                    obsData.push_back(bus.imem_wdata);
                    void'(expData.pop_front());
                    void'(expAddr.pop_front());
                    obsWrites++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int stallMin, input int stallMax, input int gapMax,
                                 input bit ovrInject, input bit fallInWrite);
        logic [7:0]  wbuf[$];
        logic [7:0]  sum;
        logic [31:0] expStatus;
        int          accepted;
        int          k;
        int          stall;
        int          ovrAt;
        int          writesBefore;
        bit          ovf;
        bit          ovr;
        bit          part;
        bit          stopped;
        bit          fallHere;
        sum = 8'd0; accepted = 0; k = 0; ovf = 0; ovr = 0; stopped = 0;
        writesBefore = obsWrites;
        expWr = 1'b0;
        bus.inject_start = 1'b1;
        tick();
        checkOutput("hold_on_start", 32'(bus.cpu_hold), 32'd1);
        for (int i = 0; i < txBytes.size(); i++) begin
            repeat ($urandom_range(gapMax, 0)) tick();
            bus.inject_data   = txBytes[i];
            bus.inject_strobe = ~bus.inject_strobe;
            if (accepted < 4 * DEPTH) begin
                accepted++;
                sum += txBytes[i];
                wbuf.push_back(txBytes[i]);
            end else begin
                ovf = 1'b1;
            end
            tick();
            bus.inject_data = 8'($urandom);
            if (wbuf.size() == 4) begin
                expData.push_back({wbuf[3], wbuf[2], wbuf[1], wbuf[0]});
                expAddr.push_back((BASE_ADDR + k) % ASPACE);
                k++;
                wbuf.delete();
                stall    = $urandom_range(stallMax, stallMin);
                fallHere = fallInWrite && (i == txBytes.size() - 1);
                ovrAt    = (ovrInject && !fallHere) ? $urandom_range(stall, 0) : -1;
                expWr    = 1'b1;
                for (int c = 0; c <= stall; c++) begin
                    bus.imem_ready = (c == stall);
                    if (c == ovrAt) begin
                        bus.inject_strobe = ~bus.inject_strobe;
                        ovr = 1'b1;
                    end
                    if (fallHere && c == 0) begin
                        bus.inject_start = 1'b0;
                        stopped = 1'b1;
                    end
                    tick();
                end
                bus.imem_ready = 1'b0;
                expWr = 1'b0;
            end
        end
        if (!stopped) begin
            repeat ($urandom_range(gapMax, 0)) tick();
            bus.inject_start = 1'b0;
            tick();
        end
        part = (wbuf.size() != 0);
        checkOutput("flush_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("flush_busy", 32'(bus.status[28]), 32'd1);
        tick();
        checkOutput("idle_hold", 32'(bus.cpu_hold), 32'd0);
        expStatus = {ovf, ovr, part, 1'b0, (CHK_EN ? sum : 8'd0), 4'b0000, 16'(k)};
        checkOutput("status", bus.status, expStatus);
        checkOutput("write_count", 32'(obsWrites - writesBefore), 32'(k));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int base;
        bit ovrSel;
        bit fallSel;
        bus.inject_data   = 8'd0;
        bus.inject_strobe = 1'b0;
        bus.inject_start  = 1'b0;
        bus.imem_ready    = 1'b0;
        #12;
        checkOutput("rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
        checkOutput("rst_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
        checkOutput("rst_hold", 32'(bus.cpu_hold), 32'd0);
        checkOutput("rst_status", bus.status, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] two-word load");
        base = obsData.size();
        txBytes = {8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        checkOutput("t1_word0", obsData[base], 32'h00000513);
        checkOutput("t1_word1", obsData[base + 1], 32'h00100093);
        if (CHK_EN) checkOutput("t1_checksum", 32'(bus.status[27:20]), 32'hBB);

        $display("[TB] five-cycle memory stall");
        txBytes = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        applyStimulus(5, 5, 1, 1'b0, 1'b0);

        $display("[TB] strobe during write");
        txBytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus(0, 3, 1, 1'b1, 1'b0);
        checkOutput("t3_ovr", 32'(bus.status[30]), 32'd1);

        $display("[TB] depth overflow");
        txBytes.delete();
        for (int i = 0; i < 4 * DEPTH + 4; i++) txBytes.push_back(8'($urandom));
        applyStimulus(0, 2, 1, 1'b0, 1'b0);
        checkOutput("t4_ovf", 32'(bus.status[31]), 32'd1);
        checkOutput("t4_cnt", 32'(bus.status[15:0]), 32'(DEPTH));

        $display("[TB] partial word discard");
        txBytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        applyStimulus(0, 1, 1, 1'b0, 1'b0);
        checkOutput("t5_part", 32'(bus.status[29]), 32'd1);
        checkOutput("t5_busy", 32'(bus.status[28]), 32'd0);

        $display("[TB] start falls during write");
        txBytes = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        applyStimulus(3, 3, 0, 1'b0, 1'b1);

        $display("[TB] random sessions");
        for (int s = 0; s < 16; s++) begin
            n = $urandom_range(4 * DEPTH + 6, 0);
            txBytes.delete();
            for (int i = 0; i < n; i++) txBytes.push_back(8'($urandom));
            fallSel = (n > 0 && n % 4 == 0 && n <= 4 * DEPTH) ? 1'($urandom_range(1, 0)) : 1'b0;
            ovrSel  = fallSel ? 1'b0 : 1'($urandom_range(1, 0));
            applyStimulus(0, 4, 3, ovrSel, fallSel);
        end

        $display("[TB] reset during write");
        bus.inject_start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.inject_data   = 8'(8'h10 * (i + 1));
            bus.inject_strobe = ~bus.inject_strobe;
            tick();
        end
        expData.push_back(32'h40302010);
        expAddr.push_back(BASE_ADDR);
        expWr = 1'b1;
        bus.imem_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        bus.inject_start = 1'b0;
        #1;
        checkOutput("abort_wr_en", 32'(bus.imem_wr_en), 32'd0);
        checkOutput("abort_hold", 32'(bus.cpu_hold), 32'd0);
        checkOutput("abort_status", bus.status, 32'd0);
        expData.delete();
        expAddr.delete();
        expWr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        checkOutput("post_abort_status", bus.status, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
